// File: rtl/ga23_pkg.sv
// Shared types and sizes for the GA23 VRAM scheduler slice.
package ga23_pkg;

    typedef enum logic {
        ROTATE = 1'b0,
        RS     = 1'b1
    } sched_mode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        ISSUED = 2'd2
    } cpu_st_t;

    localparam int unsigned NUM_LAYERS = 3;
    localparam int unsigned SLOTS      = 8;
    localparam int unsigned RS_LEN     = 16;
    localparam int unsigned VRAM_AW    = 15;

endpackage

// File: rtl/ga23_cpu_port.sv
// CPU side of the VRAM port: request latch, IDLE/PEND/ISSUED handshake,
// busy flag and read-data register. Slot timing comes from the scheduler.
module ga23_cpu_port
    import ga23_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [VRAM_AW-1:0] cpu_addr,
    input  logic [15:0]        cpu_wdata,
    input  logic               issue,
    input  logic               complete,
    input  logic [15:0]        vram_rdata,
    output logic               pend,
    output logic               issued,
    output logic               req_we,
    output logic [VRAM_AW-1:0] req_addr,
    output logic [15:0]        req_wdata,
    output logic               cpu_busy,
    output logic [15:0]        cpu_rdata
);

    cpu_st_t cpu_st, cpu_st_next;

    // Handshake state register; requests are taken on any clk, not only on ce.
    always_ff @(posedge clk) begin
        if (!reset_n) cpu_st <= IDLE;
        else          cpu_st <= cpu_st_next;
    end

    // Next-state logic: a request while not IDLE is ignored.
    always_comb begin
        cpu_st_next = cpu_st;
        unique case (cpu_st)
            IDLE:    if (cpu_req)  cpu_st_next = PEND;
            PEND:    if (issue)    cpu_st_next = ISSUED;
            ISSUED:  if (complete) cpu_st_next = IDLE;
            default:               cpu_st_next = IDLE;
        endcase
    end

    // Capture the access parameters at the moment the request is accepted.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
        end else if (cpu_st == IDLE && cpu_req) begin
            req_we    <= cpu_we;
            req_addr  <= cpu_addr;
            req_wdata <= cpu_wdata;
        end
    end

    // Read data is taken on completion for reads and writes alike.
    always_ff @(posedge clk) begin
        if (!reset_n)                        cpu_rdata <= '0;
        else if (cpu_st == ISSUED && complete) cpu_rdata <= vram_rdata;
    end

    assign pend     = (cpu_st == PEND);
    assign issued   = (cpu_st == ISSUED);
    assign cpu_busy = (cpu_st != IDLE);

endmodule

// File: rtl/ga23_vram_sched.sv
// GA23 VRAM time-slot scheduler: rotates the single VRAM port between the
// three tilemap layers and the CPU, and inserts a 16-ce rowscroll burst per line.
module ga23_vram_sched
    import ga23_pkg::*;
#(
    parameter logic [14:0] RS_BASE   = 15'h7a00,
    parameter logic [14:0] RS_STRIDE = 15'h0200,
    parameter logic [2:0]  CPU_SLOT  = 3'd6
)(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        hpulse,
    input  logic [9:0]  ve,
    input  logic [29:0] y_ofs,
    input  logic [44:0] layer_addr,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [14:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_busy,
    output logic [15:0] cpu_rdata,
    output logic [14:0] vram_addr,
    output logic [15:0] vram_wdata,
    output logic        vram_we,
    input  logic [15:0] vram_rdata,
    output logic [2:0]  layer_load,
    output logic [15:0] index_latch,
    output logic [29:0] rowscroll
);

    sched_mode_t        mode, mode_next;
    logic [2:0]         slot;
    logic [3:0]         rs_cyc;
    logic               rs_pending;

    logic [1:0]         lay_idx;
    logic [VRAM_AW-1:0] lay_sel;
    logic               layer_slot;
    logic [1:0]         rs_idx;
    logic               rs_field;
    logic [9:0]         rs_yofs;
    logic [9:0]         rs_sum;
    logic [VRAM_AW-1:0] rs_ofs;
    logic [VRAM_AW-1:0] rs_addr;

    logic               cpu_pend, cpu_issued, req_we;
    logic [VRAM_AW-1:0] req_addr;
    logic [15:0]        req_wdata;
    logic               issue, complete;

    ga23_cpu_port u_cpu_port (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .issue      (issue),
        .complete   (complete),
        .vram_rdata (vram_rdata),
        .pend       (cpu_pend),
        .issued     (cpu_issued),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .cpu_busy   (cpu_busy),
        .cpu_rdata  (cpu_rdata)
    );

    // Per-slot layer address select and rowscroll table address.
    always_comb begin
        lay_idx    = slot[2:1];
        layer_slot = (slot < 3'(2 * NUM_LAYERS));
        lay_sel    = '0;
        unique case (lay_idx)
            2'd0:    lay_sel = layer_addr[14:0];
            2'd1:    lay_sel = layer_addr[29:15];
            2'd2:    lay_sel = layer_addr[44:30];
            default: lay_sel = '0;
        endcase

        rs_idx   = rs_cyc[3:2];
        rs_field = (rs_idx < 2'(NUM_LAYERS));
        rs_yofs  = '0;
        rs_ofs   = '0;
        unique case (rs_idx)
            2'd0:    begin rs_yofs = y_ofs[9:0];   rs_ofs = '0;                end
            2'd1:    begin rs_yofs = y_ofs[19:10]; rs_ofs = RS_STRIDE;         end
            2'd2:    begin rs_yofs = y_ofs[29:20]; rs_ofs = RS_STRIDE << 1;    end
            default: begin rs_yofs = '0;           rs_ofs = '0;                end
        endcase
        rs_sum  = rs_yofs + ve;
        rs_addr = RS_BASE + rs_ofs + {6'b0, rs_sum[8:0]};
    end

    // CPU issue/complete windows; layer slots always win the port.
    assign issue    = ce && (mode == ROTATE) && !layer_slot && (slot == CPU_SLOT) && cpu_pend;
    assign complete = ce && (mode == ROTATE) && (slot == CPU_SLOT + 3'd1) && cpu_issued;

    // Mode register.
    always_ff @(posedge clk) begin
        if (!reset_n) mode <= ROTATE;
        else          mode <= mode_next;
    end

    // Mode transitions: enter the burst at slot 7 when pending, leave after RS_LEN ce.
    always_comb begin
        mode_next = mode;
        if (ce) begin
            unique case (mode)
                ROTATE:  if (slot == 3'(SLOTS - 1) && rs_pending) mode_next = RS;
                RS:      if (rs_cyc == 4'(RS_LEN - 1))             mode_next = ROTATE;
                default: mode_next = ROTATE;
            endcase
        end
    end

    // Slot / burst counters; hpulse forces slot 7 and arms a burst in either mode.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            slot       <= '0;
            rs_cyc     <= '0;
            rs_pending <= 1'b0;
        end else if (ce) begin
            if (mode == ROTATE) begin
                slot <= slot + 3'd1;
                if (slot == 3'(SLOTS - 1) && rs_pending) begin
                    rs_cyc     <= '0;
                    rs_pending <= 1'b0;
                end
            end else begin
                rs_cyc <= rs_cyc + 4'd1;
                if (rs_cyc == 4'(RS_LEN - 1)) slot <= '0;
            end
            if (hpulse) begin
                slot       <= 3'(SLOTS - 1);
                rs_pending <= 1'b1;
            end
        end
    end

    // VRAM address/data mux and the layer/rowscroll output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vram_addr   <= '0;
            vram_wdata  <= '0;
            vram_we     <= 1'b0;
            layer_load  <= '0;
            index_latch <= '0;
            rowscroll   <= '0;
        end else begin
            vram_we <= 1'b0;
            if (ce) begin
                layer_load <= '0;
                if (mode == ROTATE) begin
                    if (layer_slot) begin
                        if (!slot[0]) begin
                            vram_addr <= lay_sel;
                        end else begin
                            vram_addr[0]        <= 1'b1;
                            index_latch         <= vram_rdata;
                            layer_load[lay_idx] <= 1'b1;
                        end
                    end else if (issue) begin
                        vram_addr  <= req_addr;
                        vram_wdata <= req_wdata;
                        vram_we    <= req_we;
                    end
                end else if (rs_field) begin
                    if (rs_cyc[1:0] == 2'd1) vram_addr <= rs_addr;
                    if (rs_cyc[1:0] == 2'd2) begin
                        unique case (rs_idx)
                            2'd0:    rowscroll[9:0]   <= vram_rdata[9:0];
                            2'd1:    rowscroll[19:10] <= vram_rdata[9:0];
                            default: rowscroll[29:20] <= vram_rdata[9:0];
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ga23_vram_sched.sv
// Directed self-checking bench for ga23_vram_sched with a combinational VRAM model.
module tb_ga23_vram_sched;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce = 1'b1;
    logic        hpulse = 1'b0;
    logic [9:0]  ve = '0;
    logic [29:0] y_ofs = '0;
    logic [44:0] layer_addr = '0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [14:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic        cpu_busy;
    logic [15:0] cpu_rdata;
    logic [14:0] vram_addr;
    logic [15:0] vram_wdata;
    logic        vram_we;
    logic [15:0] vram_rdata;
    logic [2:0]  layer_load;
    logic [15:0] index_latch;
    logic [29:0] rowscroll;

    logic [15:0] mem [0:32767];
    int checks = 0;
    int errors = 0;
    int we_count = 0;

    always #5 clk = ~clk;

    assign vram_rdata = mem[vram_addr];

    always @(posedge clk) begin
        if (vram_we) begin
            mem[vram_addr] <= vram_wdata;
            we_count <= we_count + 1;
        end
    end

    ga23_vram_sched #(
        .RS_BASE   (15'h7a00),
        .RS_STRIDE (15'h0200),
        .CPU_SLOT  (3'd6)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ce          (ce),
        .hpulse      (hpulse),
        .ve          (ve),
        .y_ofs       (y_ofs),
        .layer_addr  (layer_addr),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_busy    (cpu_busy),
        .cpu_rdata   (cpu_rdata),
        .vram_addr   (vram_addr),
        .vram_wdata  (vram_wdata),
        .vram_we     (vram_we),
        .vram_rdata  (vram_rdata),
        .layer_load  (layer_load),
        .index_latch (index_latch),
        .rowscroll   (rowscroll)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cpu_req = 1'b1;
        cpu_we  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({vram_addr, vram_wdata, vram_we, layer_load, index_latch,
                 cpu_rdata, rowscroll, cpu_busy} !== '0) begin
                errors++;
                $display("FAIL reset_outputs clk%0d: addr=%h wdata=%h we=%b load=%b idx=%h rdata=%h rs=%h busy=%b, expected all 0",
                         i, vram_addr, vram_wdata, vram_we, layer_load, index_latch, cpu_rdata, rowscroll, cpu_busy);
            end
        end
        checks++;
        if (we_count !== 0) begin
            errors++;
            $display("FAIL reset_no_write: got %0d writes, expected 0", we_count);
        end
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
    endtask

    task automatic test_rotation();
        logic [14:0] ea [8];
        logic [2:0]  el [8];
        logic [15:0] ei [8];
        logic [15:0] exp_idx;
        ea = '{15'h0100, 15'h0101, 15'h0200, 15'h0201, 15'h0300, 15'h0301, 15'h0301, 15'h0301};
        el = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b000};
        ei = '{16'h0000, 16'h1111, 16'h1111, 16'h2222, 16'h2222, 16'h3333, 16'h3333, 16'h3333};
        layer_addr = {15'h0300, 15'h0200, 15'h0100};
        mem[15'h0100] = 16'h1111;
        mem[15'h0200] = 16'h2222;
        mem[15'h0300] = 16'h3333;
        reset_n = 1'b1;
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 8; k++) begin
                tick();
                exp_idx = (p == 0 || k != 0) ? ei[k] : 16'h3333;
                checks++;
                if (vram_addr !== ea[k]) begin
                    errors++;
                    $display("FAIL rot_addr pass%0d slot%0d: got %h expected %h", p, k, vram_addr, ea[k]);
                end
                checks++;
                if (layer_load !== el[k]) begin
                    errors++;
                    $display("FAIL rot_load pass%0d slot%0d: got %b expected %b", p, k, layer_load, el[k]);
                end
                checks++;
                if (index_latch !== exp_idx) begin
                    errors++;
                    $display("FAIL rot_index pass%0d slot%0d: got %h expected %h", p, k, index_latch, exp_idx);
                end
            end
        end
    endtask

    task automatic test_cpu_write();
        int w0;
        w0 = we_count;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h1234; cpu_wdata = 16'hBEEF;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 1) begin cpu_req = 1'b0; cpu_we = 1'b0; end
            checks++;
            if (cpu_busy !== (k <= 7)) begin
                errors++;
                $display("FAIL wr_busy edge%0d: got %b expected %b", k, cpu_busy, (k <= 7));
            end
            checks++;
            if (vram_we !== (k == 7)) begin
                errors++;
                $display("FAIL wr_we edge%0d: got %b expected %b", k, vram_we, (k == 7));
            end
            if (k == 7) begin
                checks++;
                if (vram_addr !== 15'h1234 || vram_wdata !== 16'hBEEF) begin
                    errors++;
                    $display("FAIL wr_issue: got addr %h data %h expected 1234 BEEF", vram_addr, vram_wdata);
                end
            end
        end
        checks++;
        if (we_count - w0 !== 1 || mem[15'h1234] !== 16'hBEEF) begin
            errors++;
            $display("FAIL wr_result: got %0d writes mem=%h expected 1 BEEF", we_count - w0, mem[15'h1234]);
        end
    endtask

    task automatic test_cpu_read();
        int w0;
        w0 = we_count;
        mem[15'h0042] = 16'h5A5A;
        mem[15'h0099] = 16'hDEAD;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0042;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 1) cpu_addr = 15'h0099;
            if (k == 3) cpu_req = 1'b0;
            checks++;
            if (cpu_busy !== (k <= 7)) begin
                errors++;
                $display("FAIL rd_busy edge%0d: got %b expected %b", k, cpu_busy, (k <= 7));
            end
            if (k == 7) begin
                checks++;
                if (vram_addr !== 15'h0042 || vram_we !== 1'b0) begin
                    errors++;
                    $display("FAIL rd_issue: got addr %h we %b expected 0042 0", vram_addr, vram_we);
                end
            end
        end
        checks++;
        if (cpu_rdata !== 16'h5A5A) begin
            errors++;
            $display("FAIL rd_data: got %h expected 5A5A", cpu_rdata);
        end
        checks++;
        if (we_count !== w0) begin
            errors++;
            $display("FAIL rd_no_write: got %0d writes expected 0", we_count - w0);
        end
    endtask

    task automatic test_rowscroll();
        mem[15'h7a01] = 16'hFC12;
        mem[15'h7c02] = 16'h0345;
        mem[15'h7e02] = 16'h8177;
        y_ofs = {10'h000, 10'h000, 10'h3FF};
        ve = 10'd2;
        hpulse = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            hpulse = 1'b0;
            if (k >= 2 && k <= 18) begin
                checks++;
                if (layer_load !== 3'b000) begin
                    errors++;
                    $display("FAIL rs_no_load edge%0d: got %b expected 000", k, layer_load);
                end
            end
            if (k == 1 || k == 19) begin
                checks++;
                if (vram_addr !== 15'h0100) begin
                    errors++;
                    $display("FAIL rs_slot0 edge%0d: got %h expected 0100", k, vram_addr);
                end
            end
            if (k == 4) begin
                checks++;
                if (vram_addr !== 15'h7a01) begin
                    errors++;
                    $display("FAIL rs_addr0: got %h expected 7a01", vram_addr);
                end
            end
            if (k == 5) begin
                checks++;
                if (rowscroll[9:0] !== 10'h012) begin
                    errors++;
                    $display("FAIL rs_val0: got %h expected 012", rowscroll[9:0]);
                end
            end
            if (k == 8) begin
                checks++;
                if (vram_addr !== 15'h7c02) begin
                    errors++;
                    $display("FAIL rs_addr1: got %h expected 7c02", vram_addr);
                end
            end
            if (k == 12 || k == 18) begin
                checks++;
                if (vram_addr !== 15'h7e02) begin
                    errors++;
                    $display("FAIL rs_addr2 edge%0d: got %h expected 7e02", k, vram_addr);
                end
            end
            if (k == 20) begin
                checks++;
                if (layer_load !== 3'b001 || rowscroll !== {10'h177, 10'h345, 10'h012}) begin
                    errors++;
                    $display("FAIL rs_resume: got load %b rs %h expected 001 %h",
                             layer_load, rowscroll, {10'h177, 10'h345, 10'h012});
                end
            end
        end
        for (int k = 0; k < 6; k++) tick();
    endtask

    task automatic test_collision();
        int we_k, we_n, fall_k, high_cnt;
        we_k = 0; we_n = 0; fall_k = 0; high_cnt = 0;
        tick();
        tick();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0555; cpu_wdata = 16'h1357;
        hpulse = 1'b1;
        tick();
        cpu_req = 1'b0; cpu_we = 1'b0; hpulse = 1'b0;
        for (int k = 2; k <= 40; k++) begin
            tick();
            if (vram_we) begin
                we_k = k;
                we_n++;
                checks++;
                if (vram_addr !== 15'h0555) begin
                    errors++;
                    $display("FAIL col_addr: got %h expected 0555", vram_addr);
                end
            end
            if (cpu_busy) high_cnt++;
            else begin
                fall_k = k;
                break;
            end
        end
        checks++;
        if (fall_k !== 26) begin
            errors++;
            $display("FAIL col_busy_fall: got edge %0d expected 26 (0 means still busy at limit)", fall_k);
        end
        checks++;
        if (we_k !== 25 || we_n !== 1) begin
            errors++;
            $display("FAIL col_we: got edge %0d count %0d expected edge 25 count 1", we_k, we_n);
        end
        checks++;
        if (high_cnt > 24) begin
            errors++;
            $display("FAIL col_latency: got %0d ce busy expected <= 24", high_cnt);
        end
        checks++;
        if (mem[15'h0555] !== 16'h1357) begin
            errors++;
            $display("FAIL col_mem: got %h expected 1357", mem[15'h0555]);
        end
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = '0;
        test_reset();
        test_rotation();
        test_cpu_write();
        test_cpu_read();
        test_rowscroll();
        test_collision();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
